// File: rtl/bullet_ctrl_pkg.sv
// Shared screen geometry, owner encoding and slot request/probe types
// for the bullet controller.
package bullet_ctrl_pkg;
  localparam int SCR_W     = 640;
  localparam int SCR_H     = 480;
  localparam int BULLET_SZ = 6;
  localparam int Y_LIMIT   = SCR_H - BULLET_SZ;

  typedef enum logic { OWN_PLAYER = 1'b0, OWN_ENEMY = 1'b1 } owner_e;
  typedef enum logic { SLOT_FREE = 1'b0, SLOT_FLY = 1'b1 } slot_state_e;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    owner_e     own;
  } spawn_t;

  // Per-slot answer to "does the current scan pixel fall on you?"
  typedef struct packed {
    logic       hit;
    owner_e     own;
    logic [2:0] ofs_x;
    logic [2:0] ofs_y;
  } probe_t;
endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: FREE/FLY state, position, owner, vertical motion with
// off-screen retirement, and the sprite hit test against the scan pixel.
module bullet_slot
  import bullet_ctrl_pkg::*;
#(
  parameter int SPEED = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       load,
  input  logic       clr,
  input  spawn_t     spawn,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic       active,
  output probe_t     probe
);
  slot_state_e st, st_nxt;
  logic [9:0]  x, y, y_nxt;
  owner_e      own;
  logic        retire;
  logic [10:0] x_end, y_end;

  // Retire before the step would leave the visible band, so nothing wraps.
  always_comb begin
    retire = 1'b0;
    y_nxt  = y;
    if (own == OWN_PLAYER) begin
      retire = y < 10'(SPEED);
      y_nxt  = y - 10'(SPEED);
    end else begin
      retire = ({1'b0, y} + 11'(SPEED)) > 11'(Y_LIMIT);
      y_nxt  = y + 10'(SPEED);
    end
  end

  always_comb begin
    st_nxt = st;
    case (st)
      SLOT_FREE: if (load) st_nxt = SLOT_FLY;
      SLOT_FLY:  if (clr || (frame_tick && retire)) st_nxt = SLOT_FREE;
      default:   st_nxt = SLOT_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= SLOT_FREE;
    else        st <= st_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x   <= '0;
      y   <= '0;
      own <= OWN_PLAYER;
    end else if (load && st == SLOT_FREE) begin
      x   <= spawn.x;
      y   <= spawn.y;
      own <= spawn.own;
    end else if (st == SLOT_FLY && !clr && frame_tick && !retire) begin
      y <= y_nxt;
    end
  end

  assign active = (st == SLOT_FLY);
  assign x_end  = {1'b0, x} + 11'(BULLET_SZ - 1);
  assign y_end  = {1'b0, y} + 11'(BULLET_SZ - 1);

  always_comb begin
    probe       = '0;
    probe.hit   = active && (pix_x >= x) && ({1'b0, pix_x} <= x_end)
                         && (pix_y >= y) && ({1'b0, pix_y} <= y_end);
    probe.own   = own;
    probe.ofs_x = pix_x[2:0] - x[2:0];
    probe.ofs_y = pix_y[2:0] - y[2:0];
  end
endmodule

// File: rtl/bullet_ctrl.sv
// Bullet pool: round-robin fire arbitration with per-requester cooldown,
// lowest-free-slot allocation, and registered sprite ROM addressing.
module bullet_ctrl
  import bullet_ctrl_pkg::*;
#(
  parameter int NB       = 4,
  parameter int SPEED    = 4,
  parameter int COOLDOWN = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_tick,
  input  logic [1:0]    fire_req,
  input  logic [9:0]    fire_x0,
  input  logic [9:0]    fire_y0,
  input  logic [9:0]    fire_x1,
  input  logic [9:0]    fire_y1,
  output logic [1:0]    fire_ack,
  input  logic [NB-1:0] hit_clr,
  output logic [NB-1:0] active,
  input  logic [9:0]    pix_x,
  input  logic [9:0]    pix_y,
  output logic [2:0]    rom_x,
  output logic [2:0]    rom_y,
  output logic          rom_en,
  output logic          pix_owner
);
  localparam int CW = $clog2(COOLDOWN + 2);

  logic [1:0][CW-1:0] cd;
  logic               rr;
  logic [1:0]         elig;
  logic               any_free, gnt_vld, gnt_id, found;
  logic [NB-1:0]      load;
  spawn_t [1:0]       spawn_src;
  spawn_t             spawn;
  probe_t [NB-1:0]    probe;
  probe_t             sel;

  assign spawn_src[0] = '{x: fire_x0, y: fire_y0, own: OWN_PLAYER};
  assign spawn_src[1] = '{x: fire_x1, y: fire_y1, own: OWN_ENEMY};

  // Freeness comes from registered state, so a slot cleared this cycle
  // only becomes allocatable next cycle.
  assign any_free = ~&active;

  always_comb begin
    elig = '0;
    for (int r = 0; r < 2; r++)
      elig[r] = fire_req[r] && (cd[r] == '0) && any_free;
  end

  assign gnt_vld = |elig;
  assign gnt_id  = (elig == 2'b11) ? rr : elig[1];
  assign spawn   = spawn_src[gnt_id];

  always_comb begin
    load  = '0;
    found = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (!active[i] && !found) begin
        load[i] = gnt_vld;
        found   = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_slot
    bullet_slot #(.SPEED(SPEED)) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .load       (load[i]),
      .clr        (hit_clr[i]),
      .spawn      (spawn),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .active     (active[i]),
      .probe      (probe[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd       <= '0;
      rr       <= 1'b0;
      fire_ack <= '0;
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (gnt_vld && (gnt_id == 1'(r))) cd[r] <= CW'(COOLDOWN);
        else if (frame_tick && cd[r] != '0) cd[r] <= cd[r] - CW'(1);
      end
      if (gnt_vld) rr <= ~rr;
      fire_ack[0] <= gnt_vld & ~gnt_id;
      fire_ack[1] <= gnt_vld &  gnt_id;
    end
  end

  // Lowest-index hit wins; sel stays all-zero when nothing is under the pixel.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NB; i++)
      if (probe[i].hit && !sel.hit) sel = probe[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_en    <= 1'b0;
      rom_x     <= '0;
      rom_y     <= '0;
      pix_owner <= 1'b0;
    end else begin
      rom_en    <= sel.hit;
      rom_x     <= sel.ofs_x;
      rom_y     <= sel.ofs_y;
      pix_owner <= sel.own;
    end
  end
endmodule
